// File: rtl/stopwatch_if.sv
// Board-side bundle for the stopwatch controller: raw buttons, mode switch,
// live counter digits in, counter commands and display digits out.
interface stopwatch_if;
    logic       Start_Stop;
    logic       Clear;
    logic       Lap;
    logic       Countdown;
    logic [3:0] Minutes_in;
    logic [3:0] Tens_in;
    logic [3:0] Ones_in;
    logic [3:0] Tenths_in;
    logic       cnt_en;
    logic       cnt_clear;
    logic       cnt_down;
    logic       running;
    logic       alarm;
    logic [3:0] Disp_Minutes;
    logic [3:0] Disp_Tens;
    logic [3:0] Disp_Ones;
    logic [3:0] Disp_Tenths;

    modport master (
        output Start_Stop, Clear, Lap, Countdown,
        output Minutes_in, Tens_in, Ones_in, Tenths_in,
        input  cnt_en, cnt_clear, cnt_down, running, alarm,
        input  Disp_Minutes, Disp_Tens, Disp_Ones, Disp_Tenths
    );

    modport slave (
        input  Start_Stop, Clear, Lap, Countdown,
        input  Minutes_in, Tens_in, Ones_in, Tenths_in,
        output cnt_en, cnt_clear, cnt_down, running, alarm,
        output Disp_Minutes, Disp_Tens, Disp_Ones, Disp_Tenths
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the BCD stopwatch counter: button conditioning,
// tenth-second prescaler, terminal-value stop and lap snapshot for the display.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 5_000_000
) (
    input logic        clk,
    input logic        reset,
    stopwatch_if.slave sw
);
    localparam int PW = $clog2(TICK_DIV);
    typedef logic [PW-1:0] presc_t;
    localparam presc_t PRESC_LAST = presc_t'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    // Button lanes: [0] Start_Stop, [1] Clear, [2] Lap
    logic [2:0] raw, sync1, sync2, sync3, ev;
    logic       ev_ss, ev_clr, ev_lap;

    state_t     state, state_n;
    presc_t     presc, presc_n;
    logic       en_r, en_n;
    logic       clr_r, clr_n;
    logic       down_r, down_n;
    logic       lap_hold, lap_n;
    logic [15:0] lap_digits, lapd_n;
    logic [15:0] live;
    logic        at_zero, at_top, terminal, wrap, lap_toggle;

    assign raw    = {sw.Lap, sw.Clear, sw.Start_Stop};
    assign ev_ss  = ev[0];
    assign ev_clr = ev[1];
    assign ev_lap = ev[2];

    // Two-flop synchronizer, then a registered rising-edge pulse per button
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
            ev    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            sync3 <= sync2;
            ev    <= sync2 & ~sync3;
        end
    end

    assign live     = {sw.Minutes_in, sw.Tens_in, sw.Ones_in, sw.Tenths_in};
    assign at_zero  = (live == 16'h0000);
    assign at_top   = (live == 16'h9599);
    assign terminal = down_r ? at_zero : at_top;
    assign wrap     = (presc == PRESC_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            en_r       <= 1'b0;
            clr_r      <= 1'b0;
            down_r     <= 1'b0;
            lap_hold   <= 1'b0;
            lap_digits <= '0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            en_r       <= en_n;
            clr_r      <= clr_n;
            down_r     <= down_n;
            lap_hold   <= lap_n;
            lap_digits <= lapd_n;
        end
    end

    // Clear outranks Start_Stop outranks Lap; a losing event is simply dropped.
    always_comb begin
        state_n    = state;
        presc_n    = '0;
        en_n       = 1'b0;
        clr_n      = 1'b0;
        down_n     = down_r;
        lap_n      = lap_hold;
        lapd_n     = lap_digits;
        lap_toggle = 1'b0;
        case (state)
            IDLE: begin
                if (ev_clr) begin
                    clr_n = 1'b1;
                    lap_n = 1'b0;
                end else if (ev_ss && !(sw.Countdown && at_zero)) begin
                    state_n = RUN;
                    down_n  = sw.Countdown;
                end
            end
            RUN: begin
                if (ev_ss) begin
                    state_n = PAUSE;
                end else if (wrap && terminal) begin
                    state_n = DONE;
                    lap_n   = 1'b0;
                end else begin
                    presc_n    = wrap ? '0 : presc + 1'b1;
                    en_n       = wrap;
                    lap_toggle = ev_lap;
                end
            end
            PAUSE: begin
                if (ev_clr) begin
                    state_n = IDLE;
                    clr_n   = 1'b1;
                    lap_n   = 1'b0;
                end else if (ev_ss) begin
                    state_n = RUN;
                end else begin
                    lap_toggle = ev_lap;
                end
            end
            DONE: begin
                if (ev_clr) begin
                    state_n = IDLE;
                    clr_n   = 1'b1;
                    lap_n   = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (lap_toggle) begin
            lap_n = ~lap_hold;
            if (!lap_hold) lapd_n = live;
        end
    end

    assign sw.cnt_en    = en_r;
    assign sw.cnt_clear = clr_r;
    assign sw.cnt_down  = down_r;
    assign sw.running   = (state == RUN);
    assign sw.alarm     = (state == DONE);
    assign {sw.Disp_Minutes, sw.Disp_Tens, sw.Disp_Ones, sw.Disp_Tenths} =
        lap_hold ? lap_digits : live;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button traffic, all
// checked against a tenths-count model of the controller and its counter.
module tb_stopwatch_ctrl;
    localparam int T = 4;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic clk = 1'b0;
    logic reset;
    stopwatch_if sw();

    stopwatch_ctrl #(.TICK_DIV(T)) dut (.clk(clk), .reset(reset), .sw(sw));

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model: counter value in tenths, plus controller mode and button history
    int       m_mode = M_IDLE, m_phase = 0, m_count = 0, m_lapcnt = 0;
    bit       m_en = 0, m_clr = 0, m_down = 0, m_lap = 0;
    bit [3:0] h_ss = 0, h_cl = 0, h_lp = 0;
    int       preset = -1;

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 600), 4'((v % 600) / 100), 4'((v % 100) / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit ess, ecl, elp, term, tog;
        int n_mode, n_phase, n_count, n_lapcnt;
        bit n_en, n_clr, n_down, n_lap;
        bit [3:0] n_hss, n_hcl, n_hlp;
        // a press sampled at edge k-3 after a low sample acts at edge k
        ess = h_ss[2] & ~h_ss[3];
        ecl = h_cl[2] & ~h_cl[3];
        elp = h_lp[2] & ~h_lp[3];
        n_mode = m_mode; n_phase = 0; n_lapcnt = m_lapcnt;
        n_en = 0; n_clr = 0; n_down = m_down; n_lap = m_lap; tog = 0;
        n_count = m_clr ? 0 : (m_en ? (m_down ? m_count - 1 : m_count + 1) : m_count);
        if (preset >= 0) begin
            n_count = preset;
            preset = -1;
        end
        if (reset) begin
            n_mode = M_IDLE; n_down = 0; n_lap = 0; n_lapcnt = 0;
            n_hss = 0; n_hcl = 0; n_hlp = 0;
        end else begin
            n_hss = {h_ss[2:0], sw.Start_Stop};
            n_hcl = {h_cl[2:0], sw.Clear};
            n_hlp = {h_lp[2:0], sw.Lap};
            term = m_down ? (m_count == 0) : (m_count == 5999);
            case (m_mode)
                M_IDLE: begin
                    if (ecl) n_clr = 1;
                    else if (ess && !(sw.Countdown && m_count == 0)) begin
                        n_mode = M_RUN;
                        n_down = sw.Countdown;
                    end
                end
                M_RUN: begin
                    if (ess) n_mode = M_PAUSE;
                    else if (m_phase == T - 1 && term) begin
                        n_mode = M_DONE;
                        n_lap = 0;
                    end else begin
                        n_en = (m_phase == T - 1);
                        n_phase = (m_phase + 1) % T;
                        tog = elp;
                    end
                end
                M_PAUSE: begin
                    if (ecl) begin
                        n_mode = M_IDLE; n_clr = 1; n_lap = 0;
                    end else if (ess) n_mode = M_RUN;
                    else tog = elp;
                end
                default: begin
                    if (ecl) begin
                        n_mode = M_IDLE; n_clr = 1; n_lap = 0;
                    end
                end
            endcase
            if (tog) begin
                n_lap = !m_lap;
                if (!m_lap) n_lapcnt = m_count;
            end
        end
        @(posedge clk);
        m_mode = n_mode; m_phase = n_phase; m_count = n_count; m_lapcnt = n_lapcnt;
        m_en = n_en; m_clr = n_clr; m_down = n_down; m_lap = n_lap;
        h_ss = n_hss; h_cl = n_hcl; h_lp = n_hlp;
        #1;
        {sw.Minutes_in, sw.Tens_in, sw.Ones_in, sw.Tenths_in} = bcd(m_count);
        #1;
        chk("ctrl", 32'({sw.cnt_en, sw.cnt_clear, sw.cnt_down, sw.running, sw.alarm}),
            32'({m_en, m_clr, m_down, m_mode == M_RUN, m_mode == M_DONE}));
        chk("disp", 32'({sw.Disp_Minutes, sw.Disp_Tens, sw.Disp_Ones, sw.Disp_Tenths}),
            32'(m_lap ? bcd(m_lapcnt) : bcd(m_count)));
    endtask

    task automatic pulse(input bit s, input bit c, input bit l, input int gap);
        sw.Start_Stop = s; sw.Clear = c; sw.Lap = l;
        tick();
        sw.Start_Stop = 0; sw.Clear = 0; sw.Lap = 0;
        repeat (gap) tick();
    endtask

    function automatic logic [31:0] disp();
        return 32'({sw.Disp_Minutes, sw.Disp_Tens, sw.Disp_Ones, sw.Disp_Tenths});
    endfunction

    initial begin
        int ens;
        int pick;
        sw.Start_Stop = 0; sw.Clear = 0; sw.Lap = 0; sw.Countdown = 0;
        {sw.Minutes_in, sw.Tens_in, sw.Ones_in, sw.Tenths_in} = 16'h0000;
        reset = 1;
        tick(); tick();
        chk("reset_outs", 32'({sw.cnt_en, sw.cnt_clear, sw.cnt_down, sw.running, sw.alarm}), 32'd0);
        reset = 0;
        tick();

        // Start: running appears on the third edge after the first high sample
        sw.Start_Stop = 1;
        tick(); tick(); tick();
        chk("run_not_yet", 32'(sw.running), 32'd0);
        tick();
        chk("run_at_n3", 32'(sw.running), 32'd1);
        sw.Start_Stop = 0;
        ens = 0;
        repeat (41) begin
            tick();
            ens += int'(sw.cnt_en);
        end
        chk("ten_enables", 32'(ens), 32'd10);
        chk("disp_0_01_0", disp(), 32'h0010);

        pulse(0, 1, 0, 6);
        chk("clear_in_run_ignored", 32'(sw.running), 32'd1);

        pulse(1, 0, 0, 3);
        chk("paused", 32'(sw.running), 32'd0);
        ens = 0;
        repeat (10) begin
            tick();
            ens += int'(sw.cnt_en);
        end
        chk("no_en_in_pause", 32'(ens), 32'd0);

        pulse(0, 1, 0, 3);
        chk("clear_pulse", 32'(sw.cnt_clear), 32'd1);
        tick();
        chk("clear_one_cycle", 32'(sw.cnt_clear), 32'd0);
        chk("disp_cleared", disp(), 32'h0000);

        // Countdown from 0:00.3 stops at zero without a fourth enable
        sw.Countdown = 1;
        preset = 3;
        tick();
        sw.Start_Stop = 1;
        tick();
        sw.Start_Stop = 0;
        ens = 0;
        repeat (60) begin
            tick();
            ens += int'(sw.cnt_en);
        end
        chk("down_three_en", 32'(ens), 32'd3);
        chk("down_alarm", 32'(sw.alarm), 32'd1);
        chk("down_disp_zero", disp(), 32'h0000);
        pulse(0, 1, 0, 5);
        pulse(1, 0, 0, 8);
        chk("down_zero_stays_idle", 32'(sw.running), 32'd0);

        // Count-up terminal at 9:59.9
        sw.Countdown = 0;
        preset = 5998;
        tick();
        sw.Start_Stop = 1;
        tick();
        sw.Start_Stop = 0;
        ens = 0;
        repeat (40) begin
            tick();
            ens += int'(sw.cnt_en);
        end
        chk("up_one_en", 32'(ens), 32'd1);
        chk("up_alarm", 32'(sw.alarm), 32'd1);
        chk("up_disp_9599", disp(), 32'h9599);
        pulse(1, 0, 0, 5);
        chk("start_ignored_in_done", 32'(sw.alarm), 32'd1);
        pulse(0, 1, 0, 5);

        // Lap freezes the display at the snapshot while the counter moves on
        preset = 25;
        tick();
        sw.Start_Stop = 1;
        tick();
        sw.Lap = 1;
        tick();
        sw.Start_Stop = 0; sw.Lap = 0;
        repeat (20) tick();
        chk("lap_frozen", disp(), 32'h0025);
        pulse(0, 0, 1, 5);
        pulse(1, 0, 0, 5);
        pulse(0, 0, 1, 5);
        pulse(0, 1, 0, 6);
        chk("lap_cleared", disp(), 32'h0000);

        // Clear and Start_Stop together in PAUSE: Clear wins
        pulse(1, 0, 0, 5);
        pulse(1, 0, 0, 5);
        pulse(1, 1, 0, 3);
        chk("simul_clear_pulse", 32'(sw.cnt_clear), 32'd1);
        repeat (3) tick();
        chk("simul_not_running", 32'(sw.running), 32'd0);

        // Reset in the middle of a countdown run
        sw.Countdown = 1;
        preset = 50;
        tick();
        pulse(1, 0, 0, 10);
        reset = 1;
        tick();
        chk("reset_mid_run", 32'({sw.cnt_en, sw.cnt_clear, sw.cnt_down, sw.running, sw.alarm}), 32'd0);
        reset = 0;
        tick();

        // Random button traffic, presets near the terminal values, rare resets
        repeat (3000) begin
            if ($urandom_range(0, 5) == 0) sw.Start_Stop = ~sw.Start_Stop;
            if ($urandom_range(0, 9) == 0) sw.Clear = ~sw.Clear;
            if ($urandom_range(0, 7) == 0) sw.Lap = ~sw.Lap;
            if ($urandom_range(0, 49) == 0) sw.Countdown = ~sw.Countdown;
            reset = ($urandom_range(0, 299) == 0);
            if (m_mode != M_RUN && !m_en && $urandom_range(0, 39) == 0) begin
                pick = int'($urandom_range(0, 5));
                case (pick)
                    0: preset = 0;
                    1: preset = 1;
                    2: preset = 3;
                    3: preset = 5998;
                    4: preset = 5999;
                    default: preset = int'($urandom_range(0, 5999));
                endcase
            end
            tick();
        end
        reset = 0;
        sw.Start_Stop = 0; sw.Clear = 0; sw.Lap = 0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the BCD stopwatch counter (Minutes / Tens_Seconds / Ones_Seconds / Tenths_Seconds datapath). Converts raw push-button and switch inputs into counter commands, generates the 0.1 s count enable from the system clock, stops the count at terminal values, and holds a lap (split) snapshot for the display. It sits between the board I/O and the counter and owns all run/pause/clear decisions.

## Interface
- TICK_DIV, 5_000_000: clk cycles per tenth-second (50 MHz / 10); must be ≥ 2.
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  synchronous, active-high reset.
- Start_Stop  in  1  raw button, toggles run/pause on rising edge.
- Clear  in  1  raw button, returns to zero on rising edge.
- Lap  in  1  raw button, toggles display freeze on rising edge.
- Countdown  in  1  mode switch, 1 = count down; sampled only in IDLE.
- Minutes_in, Tens_in, Ones_in, Tenths_in  in  4 each  live BCD digits from counter.
- cnt_en  out  1  one-cycle enable; counter advances one tenth when high.
- cnt_clear  out  1  one-cycle pulse; counter loads 0:00.0.
- cnt_down  out  1  count direction latched for current run.
- running  out  1  high in RUN.
- alarm  out  1  high in DONE.
- Disp_Minutes, Disp_Tens, Disp_Ones, Disp_Tenths  out  4 each  display digits.

## Operation
- Each button: 2-FF synchronizer, then rising-edge detect on synchronized level. Held buttons produce one event.
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- IDLE: Start_Stop edge → RUN, latching cnt_down <= Countdown; exception: Countdown=1 and inputs = 0:00.0 → stay IDLE. Clear edge → pulse cnt_clear, stay IDLE.
- RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 it wraps and cnt_en pulses, unless terminal value is present. Terminal: count-up with inputs 9:59.9, or count-down with inputs 0:00.0 → DONE instead, cnt_en suppressed. Start_Stop edge → PAUSE. Clear edge ignored in RUN.
- PAUSE: Start_Stop edge → RUN (prescaler resumes from 0); Clear edge → IDLE with cnt_clear pulse.
- DONE: alarm=1; Clear edge → IDLE with cnt_clear pulse; Start_Stop ignored.
- Prescaler held at 0 in every state except RUN.
- Lap: in RUN or PAUSE, Lap edge toggles lap_hold; on 0→1 the four input digits are latched. Clear edge (any state that accepts it), entry to DONE, and reset force lap_hold=0. Lap ignored in IDLE and DONE.
- Display: lap_hold ? latched digits : input digits (combinational mux).
- Same-cycle event priority: reset > Clear > Start_Stop > Lap; lower-priority events in that cycle are discarded, not queued.
- Countdown changes outside IDLE have no effect.

## Timing
- Button high first sampled at edge N → edge pulse internal after edge N+2 → state and registered outputs update at edge N+3.
- cnt_en, cnt_clear: registered, exactly one cycle wide.
- First cnt_en after entering RUN: TICK_DIV cycles after the RUN-entry edge; thereafter one every TICK_DIV cycles.
- Terminal check uses input digits at the prescaler-wrap cycle; the counter updates one cycle after cnt_en, so there is no race.
- Reset values: state IDLE, cnt_en 0, cnt_clear 0, cnt_down 0, running 0, alarm 0, lap_hold 0, latched digits 0, prescaler 0, synchronizers 0. Reset mid-run aborts immediately, with no cnt_en that cycle.

## Test plan
- TICK_DIV=4, count-up: reset, pulse Start_Stop → running=1 at N+3; cnt_en every 4 cycles; with counter model, 10 enables → digits 0:01.0.
- Pause/resume/clear: Start_Stop during RUN → PAUSE, no cnt_en; Clear → one-cycle cnt_clear, IDLE, display 0:00.0; Clear pressed during RUN → ignored.
- Countdown: Countdown=1 with counter preset 0:00.3, Start → 3 cnt_en pulses, then DONE, alarm=1, no 4th cnt_en; Start with 0:00.0 → stays IDLE.
- Count-up terminal: counter at 9:59.8 → one cnt_en to 9:59.9, then DONE, alarm=1, display 9:59.9.
- Lap: RUN at 0:02.5, Lap → display frozen at 0:02.5 while counter advances; Lap again → live; Lap then Clear (in PAUSE) → lap_hold=0.
- Simultaneous Clear+Start_Stop in PAUSE → IDLE with cnt_clear, not RUN; reset asserted mid-RUN → all outputs at reset values next cycle.
